// File: rtl/rot_coord_seq_if.sv
// ROM address/offset bus and rotated-coordinate output stream
// of the rotation coordinate sequencer.
interface rot_coord_seq_if #(
   parameter int DIR_W = 6,
   parameter int OFF_W = 5,
   parameter int KP_W  = 12
);
   logic [DIR_W-1:0] rom_dir;
   logic [7:0]       rom_a;
   logic [OFF_W-1:0] rom_x_spo;
   logic [OFF_W-1:0] rom_y_spo;
   logic             out_valid;
   logic             out_ready;
   logic [OFF_W-1:0] out_dx;
   logic [OFF_W-1:0] out_dy;
   logic [KP_W:0]    smp_x;
   logic [KP_W:0]    smp_y;
   logic [7:0]       out_idx;
   logic             out_last;

   modport master (
      output rom_dir,
      output rom_a,
      input  rom_x_spo,
      input  rom_y_spo,
      output out_valid,
      input  out_ready,
      output out_dx,
      output out_dy,
      output smp_x,
      output smp_y,
      output out_idx,
      output out_last
   );

   modport slave (
      input  rom_dir,
      input  rom_a,
      output rom_x_spo,
      output rom_y_spo,
      input  out_valid,
      output out_ready,
      input  out_dx,
      input  out_dy,
      input  smp_x,
      input  smp_y,
      input  out_idx,
      input  out_last
   );
endinterface

// File: rtl/rot_coord_seq.sv
// Walks the 16x16 rotation-ROM grid around a keypoint and streams rotated
// sample coordinates. Define ROT_SUBSAMPLE_EN for the 8x8 even-row/col sweep.
module rot_coord_seq #(
   parameter int DIR_W = 6,
   parameter int OFF_W = 5,
   parameter int KP_W  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIR_W-1:0] dir_in,
   input  logic [KP_W-1:0]  kp_x,
   input  logic [KP_W-1:0]  kp_y,
   output logic             busy,
   output logic             done,
   rot_coord_seq_if.master  bus
);

   localparam int SW = KP_W + 1;

`ifdef ROT_SUBSAMPLE_EN
   localparam logic [7:0] A_LAST = 8'hEE;
`else
   localparam logic [7:0] A_LAST = 8'hFF;
`endif

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [DIR_W-1:0] dir_q, dir_d;
   logic [KP_W-1:0]  kpx_q, kpx_d;
   logic [KP_W-1:0]  kpy_q, kpy_d;
   logic [7:0]       rom_a_q, rom_a_d;
   logic             out_valid_q, out_valid_d;
   logic [OFF_W-1:0] out_dx_q, out_dx_d;
   logic [OFF_W-1:0] out_dy_q, out_dy_d;
   logic [SW-1:0]    smp_x_q, smp_x_d;
   logic [SW-1:0]    smp_y_q, smp_y_d;
   logic [7:0]       out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;

   logic             cap;
   logic [7:0]       a_nxt;
   logic [SW-1:0]    sx_calc;
   logic [SW-1:0]    sy_calc;

   // Keypoint is zero-extended, ROM offset sign-extended; the extra bit
   // always holds the full result.
   assign sx_calc = {1'b0, kpx_q}
                  + {{(SW-OFF_W){bus.rom_x_spo[OFF_W-1]}}, bus.rom_x_spo};
   assign sy_calc = {1'b0, kpy_q}
                  + {{(SW-OFF_W){bus.rom_y_spo[OFF_W-1]}}, bus.rom_y_spo};

`ifdef ROT_SUBSAMPLE_EN
   always_comb begin
      if (rom_a_q[3:0] == 4'hE) begin
         a_nxt = {rom_a_q[7:4] + 4'd2, 4'h0};
      end else begin
         a_nxt = rom_a_q + 8'd2;
      end
   end
`else
   assign a_nxt = rom_a_q + 8'd1;
`endif

   assign cap = !out_valid_q || bus.out_ready;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dir_d       = dir_q;
      kpx_d       = kpx_q;
      kpy_d       = kpy_q;
      rom_a_d     = rom_a_q;
      out_valid_d = out_valid_q;
      out_dx_d    = out_dx_q;
      out_dy_d    = out_dy_q;
      smp_x_d     = smp_x_q;
      smp_y_d     = smp_y_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      unique case (state_q)
         IDLE: begin
            // The done cycle is still the tail of the previous sweep.
            if (start && !done_q) begin
               dir_d   = dir_in;
               kpx_d   = kp_x;
               kpy_d   = kp_y;
               rom_a_d = 8'h00;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cap) begin
               out_dx_d    = bus.rom_x_spo;
               out_dy_d    = bus.rom_y_spo;
               smp_x_d     = sx_calc;
               smp_y_d     = sy_calc;
               out_idx_d   = rom_a_q;
               out_valid_d = 1'b1;
               out_last_d  = (rom_a_q == A_LAST);
               if (rom_a_q == A_LAST) begin
                  state_d = DRAIN;
               end else begin
                  rom_a_d = a_nxt;
               end
            end
         end
         DRAIN: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dir_q       <= '0;
         kpx_q       <= '0;
         kpy_q       <= '0;
         rom_a_q     <= 8'h00;
         out_valid_q <= 1'b0;
         out_dx_q    <= '0;
         out_dy_q    <= '0;
         smp_x_q     <= '0;
         smp_y_q     <= '0;
         out_idx_q   <= 8'h00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dir_q       <= dir_d;
         kpx_q       <= kpx_d;
         kpy_q       <= kpy_d;
         rom_a_q     <= rom_a_d;
         out_valid_q <= out_valid_d;
         out_dx_q    <= out_dx_d;
         out_dy_q    <= out_dy_d;
         smp_x_q     <= smp_x_d;
         smp_y_q     <= smp_y_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign bus.rom_dir   = dir_q;
   assign bus.rom_a     = rom_a_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_dx    = out_dx_q;
   assign bus.out_dy    = out_dy_q;
   assign bus.smp_x     = smp_x_q;
   assign bus.smp_y     = smp_y_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rot_coord_seq.sv
// Scoreboard bench for rot_coord_seq: directed sweeps, stalls,
// restart/ignore cases and mid-sweep reset.
module tb_rot_coord_seq;

   localparam int DIR_W = 6;
   localparam int OFF_W = 5;
   localparam int KP_W  = 12;

`ifdef ROT_SUBSAMPLE_EN
   localparam logic [7:0]  LAST_IDX = 8'hEE;
   localparam int          RST_BEAT = 50;
   localparam logic [4:0]  LAST_D   = 5'd11;
   localparam logic [12:0] LAST_SX  = 13'd111;
   localparam logic [12:0] LAST_SY  = 13'd211;
`else
   localparam logic [7:0]  LAST_IDX = 8'hFF;
   localparam int          RST_BEAT = 100;
   localparam logic [4:0]  LAST_D   = 5'd12;
   localparam logic [12:0] LAST_SX  = 13'd112;
   localparam logic [12:0] LAST_SY  = 13'd212;
`endif

   typedef struct {
      logic [7:0]  idx;
      logic [4:0]  dx;
      logic [4:0]  dy;
      logic [12:0] sx;
      logic [12:0] sy;
      logic        last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [DIR_W-1:0] dir_in;
   logic [KP_W-1:0]  kp_x;
   logic [KP_W-1:0]  kp_y;
   logic             busy;
   logic             done;
   logic             rom_mode;
   logic             ready_pat;

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   beat_t exp_q[$];
   beat_t b0;
   beat_t bl;

   rot_coord_seq_if #(.DIR_W(DIR_W), .OFF_W(OFF_W), .KP_W(KP_W)) bus ();

   rot_coord_seq #(.DIR_W(DIR_W), .OFF_W(OFF_W), .KP_W(KP_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .dir_in (dir_in),
      .kp_x   (kp_x),
      .kp_y   (kp_y),
      .busy   (busy),
      .done   (done),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // External ROM pair
   always_comb begin
      if (rom_mode) begin
         bus.rom_x_spo = 5'h10;
         bus.rom_y_spo = 5'h10;
      end else begin
         bus.rom_x_spo = {1'b0, bus.rom_a[7:4]} - 5'd3;
         bus.rom_y_spo = {1'b0, bus.rom_a[3:0]} - 5'd3;
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_sweep(logic [11:0] kx, logic [11:0] ky, logic mode);
      beat_t b;
      int ox;
      int oy;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
`ifdef ROT_SUBSAMPLE_EN
            if ((r % 2) != 0 || (c % 2) != 0) continue;
`endif
            ox = mode ? -16 : r - 3;
            oy = mode ? -16 : c - 3;
            b.idx  = 8'(r * 16 + c);
            b.dx   = 5'(ox);
            b.dy   = 5'(oy);
            b.sx   = 13'(int'(kx) + ox);
            b.sy   = 13'(int'(ky) + oy);
            b.last = (b.idx == LAST_IDX);
            exp_q.push_back(b);
         end
      end
   endtask

   // Ready pattern 1,0,0,1 when enabled, otherwise always ready
   initial begin
      int ph;
      ph = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_pat) begin
            bus.out_ready = (ph == 0) || (ph == 3);
            ph = (ph + 1) % 4;
         end else begin
            bus.out_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each transfer and checks stall hold
   initial begin
      logic        stalled;
      logic [63:0] snap;
      logic [63:0] cur;
      beat_t       e;
      beat_t       a;
      stalled = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         cur = {11'd0, bus.rom_a, bus.out_idx, bus.out_dx, bus.out_dy,
                bus.smp_x, bus.smp_y, bus.out_last};
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) chk("stall_hold", cur, snap);
            if (bus.out_valid && bus.out_ready) begin
               a.idx  = bus.out_idx;
               a.dx   = bus.out_dx;
               a.dy   = bus.out_dy;
               a.sx   = bus.smp_x;
               a.sy   = bus.smp_y;
               a.last = bus.out_last;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got idx %0h, expected none",
                           a.idx);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("beat_%02h", e.idx),
                      {13'd0, a.idx, a.dx, a.dy, a.sx, a.sy, a.last},
                      {13'd0, e.idx, e.dx, e.dy, e.sx, e.sy, e.last});
                  if (e.idx == 8'h00) b0 = a;
                  if (e.last) bl = a;
               end
               beat_cnt++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            snap = cur;
         end
      end
   end

   task automatic do_start(logic [5:0] d, logic [11:0] kx, logic [11:0] ky);
      @(posedge clk);
      #1;
      start  = 1'b1;
      dir_in = d;
      kp_x   = kx;
      kp_y   = ky;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_beats(int n);
      for (int i = 0; i < 5000 && beat_cnt < n; i++) @(posedge clk);
      #1;
      if (beat_cnt < n) chk("beat_timeout", 64'(beat_cnt), 64'(n));
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 5000; i++) begin
         if (done) break;
         @(posedge clk);
         #1;
      end
      chk("done_seen", {63'd0, done}, 64'd1);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      chk("valid_at_done", {63'd0, bus.out_valid}, 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      dir_in    = '0;
      kp_x      = '0;
      kp_y      = '0;
      rom_mode  = 1'b0;
      ready_pat = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_rom_a", {56'd0, bus.rom_a}, 64'd0);
      chk("rst_rom_dir", {58'd0, bus.rom_dir}, 64'd0);
      chk("rst_smp", {38'd0, bus.smp_x, bus.smp_y}, 64'd0);
      chk("rst_misc", {47'd0, bus.out_dx, bus.out_dy, bus.out_idx,
                       bus.out_last, done}, 64'd0);
      rst = 1'b0;

      // Nominal sweep
      beat_cnt = 0;
      push_sweep(12'd100, 12'd200, 1'b0);
      do_start(6'd12, 12'd100, 12'd200);
      chk("dir_latched", {58'd0, bus.rom_dir}, 64'd12);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      chk("no_valid_n1", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("first_valid_n2", {63'd0, bus.out_valid}, 64'd1);
      chk("first_idx", {56'd0, bus.out_idx}, 64'd0);
      wait_done();
      // start during the done cycle must be ignored
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("start_on_done_ignored", {63'd0, busy}, 64'd0);
      chk("beat0_dx", {59'd0, b0.dx}, 64'h1d);
      chk("beat0_smp", {38'd0, b0.sx, b0.sy}, {38'd0, 13'd97, 13'd197});
      chk("last_d", {54'd0, bl.dx, bl.dy}, {54'd0, LAST_D, LAST_D});
      chk("last_smp", {38'd0, bl.sx, bl.sy}, {38'd0, LAST_SX, LAST_SY});

      // Backpressure 1,0,0,1
      ready_pat = 1'b1;
      beat_cnt = 0;
      push_sweep(12'd100, 12'd200, 1'b0);
      do_start(6'd12, 12'd100, 12'd200);
      wait_done();
      ready_pat = 1'b0;

      // Negative coordinates at the image corner
      rom_mode = 1'b1;
      beat_cnt = 0;
      push_sweep(12'd0, 12'd0, 1'b1);
      do_start(6'd5, 12'd0, 12'd0);
      wait_done();
      chk("neg_dx", {54'd0, b0.dx, b0.dy}, {54'd0, 5'h10, 5'h10});
      chk("neg_smp", {38'd0, b0.sx, b0.sy}, {38'd0, 13'h1FF0, 13'h1FF0});
      rom_mode = 1'b0;

      // Start while busy is ignored
      beat_cnt = 0;
      push_sweep(12'd100, 12'd200, 1'b0);
      do_start(6'd12, 12'd100, 12'd200);
      wait_beats(40);
      do_start(6'd33, 12'd7, 12'd9);
      chk("dir_kept", {58'd0, bus.rom_dir}, 64'd12);
      wait_done();

      // Reset mid-sweep, then restart from idx 0
      beat_cnt = 0;
      push_sweep(12'd100, 12'd200, 1'b0);
      do_start(6'd12, 12'd100, 12'd200);
      wait_beats(RST_BEAT);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      chk("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      begin
         logic seen;
         seen = done;
         repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | done;
         end
         chk("rst_mid_no_done", {63'd0, seen}, 64'd0);
      end
      beat_cnt = 0;
      push_sweep(12'd100, 12'd200, 1'b0);
      do_start(6'd12, 12'd100, 12'd200);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
